// File: rtl/mem_pkg.sv
// Shared types and constants for the data memory responder and its storage array.
package mem_pkg;
    localparam int WORD_BYTES = 4;
    localparam int BE_W       = 4;

    typedef enum logic [1:0] {IDLE, WAIT, COMMIT, RESP} resp_state_t;

    typedef struct packed {
        logic            we;
        logic [31:0]     addr;
        logic [31:0]     wdata;
        logic [BE_W-1:0] be;
    } req_t;
endpackage

// File: rtl/data_mem_array.sv
// Word array with a synchronous byte-enabled write and a combinational read on one address.
module data_mem_array
    import mem_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic            clk,
    input  logic            we,
    input  logic [AW-1:0]   addr,
    input  logic [31:0]     wdata,
    input  logic [BE_W-1:0] be,
    output logic [31:0]     rdata
);
    // No reset: preloaded contents must survive reset.
    logic [31:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        for (int i = 0; i < WORD_BYTES; i++) begin
            if (we && be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
    end

    assign rdata = mem[addr];
endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding load/store responder: accept, wait LATENCY cycles, commit, respond.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int MEM_DEPTH = 1024,
    parameter int LATENCY   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);
    localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    resp_state_t state, state_nx;
    logic [3:0]  cnt, cnt_nx;
    req_t        rq;
    logic        acc, hs, bad, wr_en;
    logic [AW-1:0] idx;
    logic [31:0] rd;

    assign acc   = req_valid && req_ready;
    assign hs    = resp_valid && resp_ready;
    assign bad   = (rq.addr[1:0] != 2'b00) || ({2'b00, rq.addr[31:2]} >= 32'(MEM_DEPTH));
    assign idx   = rq.addr[AW+1:2];
    assign wr_en = (state == COMMIT) && rq.we && !bad;

    data_mem_array #(.DEPTH(MEM_DEPTH), .AW(AW)) u_array (
        .clk   (clk),
        .we    (wr_en),
        .addr  (idx),
        .wdata (rq.wdata),
        .be    (rq.be),
        .rdata (rd)
    );

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (acc) begin
                    if (LATENCY > 0) begin
                        state_nx = WAIT;
                        cnt_nx   = 4'(LATENCY);
                    end else begin
                        state_nx = COMMIT;
                    end
                end
            end
            WAIT: begin
                cnt_nx = cnt - 4'd1;
                if (cnt <= 4'd1) state_nx = COMMIT;
            end
            COMMIT:  state_nx = RESP;
            RESP:    if (hs) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            rq         <= '0;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            req_ready <= (state_nx == IDLE);
            if (acc) rq <= '{we: req_we, addr: req_addr, wdata: req_wdata, be: req_be};
            if (state == COMMIT) begin
                resp_rdata <= (bad || rq.we) ? 32'd0 : rd;
                resp_err   <= bad;
            end
            // Response is presented one cycle after entering RESP, so it appears LATENCY+2 after accept.
            if (state == RESP && !resp_valid) resp_valid <= 1'b1;
            else if (hs)                      resp_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench: stimulus queues expected responses, a monitor pops them on each handshake.
module tb_data_mem_responder;
    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_we, resp_ready, z_valid;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        z_ready, z_resp_valid, z_err;
    logic [31:0] z_rdata;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t q[$];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int acc_cyc = 0;
    logic prev_valid = 1'b0;
    logic stall = 1'b0;
    logic [31:0] held = 32'd0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    data_mem_responder #(.MEM_DEPTH(1024), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_err(resp_err)
    );

    data_mem_responder #(.MEM_DEPTH(1024), .LATENCY(0)) dut0 (
        .clk(clk), .reset(reset), .req_valid(z_valid), .req_ready(z_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(z_resp_valid), .resp_ready(resp_ready), .resp_rdata(z_rdata),
        .resp_err(z_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            prev_valid = 1'b0;
            stall      = 1'b0;
        end else begin
            if (req_valid && req_ready) acc_cyc = cyc + 1;
            if (resp_valid && !prev_valid) chk("latency", 32'(cyc - acc_cyc), 32'(LAT + 2));
            if (resp_valid && !resp_ready) begin
                if (stall) begin
                    chk("stall_rdata", resp_rdata, held);
                    chk("stall_req_ready", {31'd0, req_ready}, 32'd0);
                end
                held  = resp_rdata;
                stall = 1'b1;
            end else begin
                stall = 1'b0;
            end
            if (resp_valid && resp_ready) begin
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_resp: got rdata 0x%08h with no pending request", resp_rdata);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("rdata", resp_rdata, e.rdata);
                    chk("err", {31'd0, resp_err}, {31'd0, e.err});
                end
            end
            prev_valid = resp_valid;
        end
    end

    task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] be, input logic [31:0] er, input logic ee);
        int n = 0;
        while (!req_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (!req_ready) begin
            tests++; fails++;
            $display("FAIL req_ready_timeout: got 0 expected 1");
        end
        req_we = we; req_addr = a; req_wdata = wd; req_be = be; req_valid = 1'b1;
        q.push_back('{rdata: er, err: ee});
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (q.size() != 0 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (q.size() != 0) begin
            tests++; fails++;
            $display("FAIL resp_timeout: got %0d pending expected 0", q.size());
            q.delete();
        end
    endtask

    task automatic txn(input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] be, input logic [31:0] er, input logic ee);
        issue(we, a, wd, be, er, ee);
        wait_done();
    endtask

    task automatic z_txn(input logic we, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] be, input logic [31:0] er, input logic ee);
        int n = 0;
        chk("z_req_ready", {31'd0, z_ready}, 32'd1);
        req_we = we; req_addr = a; req_wdata = wd; req_be = be; z_valid = 1'b1;
        @(posedge clk); #1;
        z_valid = 1'b0;
        while (!z_resp_valid && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk("z_latency", 32'(n), 32'd2);
        chk("z_rdata", z_rdata, er);
        chk("z_err", {31'd0, z_err}, {31'd0, ee});
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b0; req_valid = 1'b0; z_valid = 1'b0; req_we = 1'b0;
        req_addr = 32'd0; req_wdata = 32'd0; req_be = 4'h0; resp_ready = 1'b1;
        #1;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_err", {31'd0, resp_err}, 32'd0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_req_ready", {31'd0, req_ready}, 32'd1);

        // Store then load
        txn(1'b1, 32'h10, 32'h0000_1234, 4'hF, 32'd0, 1'b0);
        txn(1'b0, 32'h10, 32'd0,         4'h0, 32'h0000_1234, 1'b0);
        // Partial store over a known word
        txn(1'b1, 32'h10, 32'hAABB_CCDD, 4'hF, 32'd0, 1'b0);
        txn(1'b1, 32'h10, 32'h0000_1100, 4'b0010, 32'd0, 1'b0);
        txn(1'b0, 32'h10, 32'd0,         4'hF, 32'hAABB_11DD, 1'b0);

        // Backpressure: response held for three cycles, accepted on the fourth
        resp_ready = 1'b0;
        issue(1'b0, 32'h10, 32'd0, 4'h0, 32'hAABB_11DD, 1'b0);
        begin
            int n = 0;
            while (!resp_valid && n < 20) begin
                @(posedge clk); #1; n++;
            end
        end
        repeat (3) @(posedge clk);
        #1;
        chk("bp_resp_valid", {31'd0, resp_valid}, 32'd1);
        chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
        chk("bp_queue_pending", 32'(q.size()), 32'd1);
        resp_ready = 1'b1;
        wait_done();

        // Errors and range boundaries
        txn(1'b0, 32'h13,   32'd0,         4'h0, 32'd0, 1'b1);
        txn(1'b1, 32'h0,    32'h0BAD_F00D, 4'hF, 32'd0, 1'b0);
        txn(1'b1, 32'h1000, 32'hFFFF_FFFF, 4'hF, 32'd0, 1'b1);
        txn(1'b1, 32'h2,    32'hFFFF_FFFF, 4'hF, 32'd0, 1'b1);
        txn(1'b1, 32'h0,    32'hFFFF_FFFF, 4'h0, 32'd0, 1'b0);
        txn(1'b0, 32'h0,    32'd0,         4'h0, 32'h0BAD_F00D, 1'b0);
        txn(1'b1, 32'hFFC,  32'h600D_CAFE, 4'hF, 32'd0, 1'b0);
        txn(1'b0, 32'hFFC,  32'd0,         4'h0, 32'h600D_CAFE, 1'b0);
        txn(1'b0, 32'h1000, 32'd0,         4'h0, 32'd0, 1'b1);

        // Reset during WAIT abandons the store
        txn(1'b1, 32'h20, 32'hCAFE_F00D, 4'hF, 32'd0, 1'b0);
        issue(1'b1, 32'h20, 32'h0000_0055, 4'hF, 32'd0, 1'b0);
        reset = 1'b0;
        #1;
        q.delete();
        chk("midrst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("midrst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("midrst_rdata", resp_rdata, 32'd0);
        chk("midrst_err", {31'd0, resp_err}, 32'd0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk); #1;
        chk("midrst_release_ready", {31'd0, req_ready}, 32'd1);
        txn(1'b0, 32'h20, 32'd0, 4'h0, 32'hCAFE_F00D, 1'b0);

        // Zero-latency instance
        z_txn(1'b1, 32'h10, 32'h1234_5678, 4'hF, 32'd0, 1'b0);
        z_txn(1'b0, 32'h10, 32'd0,         4'h0, 32'h1234_5678, 1'b0);
        z_txn(1'b0, 32'h11, 32'd0,         4'h0, 32'd0, 1'b1);

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
Memory-side responder for CPU load/store traffic. Accepts word-aligned read/write requests on a valid/ready request channel and applies them to an internal word array. Returns read data and error status on a valid/ready response channel after a programmable wait latency. Sits between the multi-cycle/pipeline CPU data port and storage, and is preloadable by $readmemh into its array named mem.

Parameters:
MEM_DEPTH, 1024, number of 32-bit words in the array
LATENCY, 2, wait cycles inserted between request accept and access commit (0..15)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset (0 = in reset)
req_valid  input  1  request present
req_ready  output  1  responder can accept a request
req_we  input  1  1 = store, 0 = load
req_addr  input  32  byte address
req_wdata  input  32  store data
req_be  input  4  byte enables, bit i covers wdata[8i+7:8i]
resp_valid  output  1  response present
resp_ready  input  1  requester accepts response
resp_rdata  output  32  load data (0 for stores and errors)
resp_err  output  1  misaligned or out-of-range access

Behaviour:
- Reset (reset=0, async): state IDLE, req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0, wait counter=0. Array contents are NOT cleared, so preloaded data survives.
- After reset deasserts, req_ready=1 from the first clock edge onward while in IDLE.
- FSM states:
  IDLE: req_ready=1. On req_valid&&req_ready, latch we/addr/wdata/be. Go to WAIT with counter=LATENCY if LATENCY>0, else go to COMMIT.
  WAIT: req_ready=0. Decrement the counter each cycle. At counter==1, go to COMMIT.
  COMMIT: single cycle, req_ready=0. Perform the access using latched fields, register rdata/err, then go to RESP.
  RESP: resp_valid=1, req_ready=0. rdata/err are held stable until resp_ready=1. On handshake, go to IDLE with resp_valid=0 the next cycle.
- Latency: resp_valid rises exactly LATENCY+2 cycles after the accept edge. No overlap between transactions (one outstanding maximum).
- Address decode: word index = req_addr[31:2].
  - Misaligned (addr[1:0]!=0): err=1, no write, rdata=0.
  - Out of range (word index >= MEM_DEPTH): err=1, no write, rdata=0.
- Store: only bytes with be=1 are updated. be=4'b0000 is a legal no-op with err=0. rdata=0.
- Load: rdata is the full word after all prior committed stores (read-after-write coherent). be is ignored.
- Request inputs are ignored when req_ready=0.
- Reset mid-transaction: the transaction is abandoned. A store is not applied unless COMMIT was already reached before reset asserted.
- resp_ready held high in IDLE/WAIT has no effect.

Decomposition:
- Package mem_pkg: typedef enum {IDLE, WAIT, COMMIT, RESP} resp_state_t; constants WORD_BYTES=4, BE_W=4.
- One sub-module, data_mem_array: synchronous byte-enable write port and combinational read port over mem[0:MEM_DEPTH-1]. The hierarchy path dut.u_array.mem is the $readmemh target.
- FSM, counter and decode live in the top.

Test Plan:
1. Store then load, LATENCY=2: store 0x00001234 to 0x10 with be=4'hF, then load 0x10 -> resp_rdata=0x00001234, err=0. resp_valid occurs 4 cycles after each accept.
2. Partial store: preload word 4 = 0xAABBCCDD, store 0x00001100 to 0x10 with be=4'b0010 -> load returns 0xAABB11DD.
3. Backpressure: hold resp_ready=0 for 3 cycles in RESP -> resp_valid stays 1, rdata stable, req_ready=0 throughout. Handshake occurs on the 4th cycle.
4. Errors: load 0x13 -> err=1, rdata=0. Store 0x1000 with MEM_DEPTH=1024 -> err=1, and word 0 is unchanged.
5. Reset mid-WAIT: issue store 0x55 to 0x20, assert reset during WAIT -> outputs go to zero immediately, later load 0x20 returns the preloaded value, and req_ready=1 after release.
6. LATENCY=0: load 0x10 -> resp_valid 2 cycles after accept.
